// File: rtl/lut_mux_fn_if.sv
// Handshake bundle for lut_mux_fn_unit: serial table-load channel,
// evaluation request channel and registered result channel.
interface lut_mux_fn_if #(
  parameter int SEL_W = 3
);
  logic             cfg_start;
  logic             cfg_valid;
  logic [1:0]       cfg_code;
  logic             cfg_done;
  logic             configured;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             w;
  logic             out_valid;
  logic             out_ready;
  logic             out;

  modport master (
    output cfg_start, cfg_valid, cfg_code, in_valid, sel, w, out_ready,
    input  cfg_done, configured, in_ready, out_valid, out
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_code, in_valid, sel, w, out_ready,
    output cfg_done, configured, in_ready, out_valid, out
  );
endinterface

// File: rtl/lut_mux_fn_unit.sv
// Run-time programmable (SEL_W+1)-input boolean function: a serially loaded
// table of {0,1,w,~w} codes indexed by sel, resolved against w into a 1-deep result register.
module lut_mux_fn_unit #(
  parameter int         SEL_W      = 3,
  parameter logic [1:0] RESET_CODE = 2'b00
) (
  input  logic         clk,
  input  logic         rst_n,
  lut_mux_fn_if.slave  bus
);
  localparam int DEPTH = 1 << SEL_W;

  typedef enum logic [1:0] {UNCFG, LOAD, RUN} state_t;

  state_t                      state_q, state_d;
  logic [SEL_W-1:0]            idx_q, idx_d;
  logic [DEPTH-1:0][1:0]       table_q, table_d;
  logic                        cfg_done_q, cfg_done_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_q, out_d;
  logic                        accept;
  logic [1:0]                  code_sel;

  assign bus.in_ready   = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign bus.configured = (state_q == RUN);
  assign bus.cfg_done   = cfg_done_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out        = out_q;

  assign accept   = bus.in_valid && bus.in_ready;
  assign code_sel = table_q[bus.sel];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    table_d    = table_q;
    cfg_done_d = 1'b0;
    case (state_q)
      UNCFG: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        // A restart outranks a data beat arriving in the same cycle.
        if (bus.cfg_start) begin
          idx_d = '0;
        end else if (bus.cfg_valid) begin
          table_d[idx_q] = bus.cfg_code;
          idx_d          = idx_q + 1'b1;
          if (idx_q == SEL_W'(DEPTH - 1)) begin
            state_d    = RUN;
            cfg_done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.cfg_start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = UNCFG;
        idx_d   = '0;
      end
    endcase
  end

  // Result stage evaluates against table_q, so same-cycle reloads never leak in.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_d       = code_sel[1] ? (bus.w ^ code_sel[0]) : code_sel[0];
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= UNCFG;
      idx_q       <= '0;
      table_q     <= {DEPTH{RESET_CODE}};
      cfg_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      table_q     <= table_d;
      cfg_done_q  <= cfg_done_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end
endmodule

// File: tb/tb_lut_mux_fn_unit.sv
// Directed bench for lut_mux_fn_unit: hand-computed vector table plus
// sequences for load restart, backpressure, reload overlap and mid-load reset.
module tb_lut_mux_fn_unit;
  localparam int SEL_W = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lut_mux_fn_if #(.SEL_W(SEL_W)) bus ();

  lut_mux_fn_unit #(.SEL_W(SEL_W), .RESET_CODE(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0] sel;
    logic       w;
    logic       exp;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] model [DEPTH];
  logic [1:0] t1 [DEPTH];
  logic [1:0] all01 [DEPTH];
  logic [1:0] all00 [DEPTH];
  logic [1:0] all10 [DEPTH];
  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic fn(input logic [1:0] code, input logic wv);
    case (code)
      2'b00:   return 1'b0;
      2'b01:   return 1'b1;
      2'b10:   return wv;
      default: return ~wv;
    endcase
  endfunction

  task automatic pulse_start();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  // Loads nbeats entries starting at 0 (state must already be LOAD).
  task automatic load(input logic [1:0] codes [DEPTH], input int nbeats, input bit gaps);
    for (int i = 0; i < nbeats; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_code  = codes[i];
      tick();
      bus.cfg_valid = 1'b0;
      if (i == DEPTH - 1) begin
        check("cfg_done_after_last", bus.cfg_done, 1'b1);
        check("configured_after_last", bus.configured, 1'b1);
      end else begin
        check("cfg_done_early", bus.cfg_done, 1'b0);
        if (gaps && i[0]) begin
          tick();
          check("cfg_done_gap", bus.cfg_done, 1'b0);
        end
      end
      model[i] = codes[i];
    end
    if (nbeats == DEPTH) begin
      tick();
      check("cfg_done_one_cycle", bus.cfg_done, 1'b0);
    end
  endtask

  // All 16 (sel,w) pairs back-to-back against the bench's table model.
  task automatic sweep(input string name);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.sel = 3'(i >> 1);
      bus.w   = i[0];
      #1;
      check({name, "_in_ready"}, bus.in_ready, 1'b1);
      tick();
      check({name, "_out_valid"}, bus.out_valid, 1'b1);
      check({name, "_out"}, bus.out, fn(model[i >> 1], i[0]));
    end
    bus.in_valid = 1'b0;
    tick();
    check({name, "_drain"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    int bad;
    t1 = '{2'b00, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01};
    foreach (all01[i]) all01[i] = 2'b01;
    foreach (all00[i]) all00[i] = 2'b00;
    foreach (all10[i]) all10[i] = 2'b10;
    vecs[0] = '{sel: 3'b001, w: 1'b0, exp: 1'b1};
    vecs[1] = '{sel: 3'b001, w: 1'b1, exp: 1'b0};
    vecs[2] = '{sel: 3'b111, w: 1'b0, exp: 1'b1};
    vecs[3] = '{sel: 3'b000, w: 1'b1, exp: 1'b0};

    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_code = 2'b00;
    bus.in_valid  = 1'b0; bus.sel = '0; bus.w = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_configured", bus.configured, 1'b0);
    check("rst_cfg_done", bus.cfg_done, 1'b0);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out", bus.out, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;

    // Unconfigured: requests and stray cfg beats are ignored
    bus.in_valid = 1'b1; bus.cfg_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.configured !== 1'b0) bad++;
    end
    check("uncfg_20_cycles_clean", bad == 0, 1'b1);
    bus.in_valid = 1'b0; bus.cfg_valid = 1'b0;

    pulse_start();
    check("load_not_configured", bus.configured, 1'b0);
    load(t1, DEPTH, 1'b1);

    foreach (vecs[i]) begin
      bus.sel = vecs[i].sel; bus.w = vecs[i].w; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      check("vec_out_valid", bus.out_valid, 1'b1);
      check("vec_out", bus.out, vecs[i].exp);
      tick();
      check("vec_consumed", bus.out_valid, 1'b0);
    end

    sweep("sweep_t1");

    // Backpressure: held result stable, in_ready low, then same-cycle accept on release
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel = 3'b001; bus.w = 1'b0;
    tick();
    bus.sel = 3'b000;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out !== 1'b1) bad++;
      tick();
    end
    check("bp_stable", bad == 0, 1'b1);
    check("bp_held_out", bus.out, 1'b1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_next_valid", bus.out_valid, 1'b1);
    check("bp_next_out", bus.out, 1'b0);
    tick();

    // cfg_start with a same-cycle accept uses the old table
    bus.cfg_start = 1'b1; bus.in_valid = 1'b1; bus.sel = 3'b001; bus.w = 1'b0;
    tick();
    bus.cfg_start = 1'b0; bus.in_valid = 1'b0;
    check("ovl_out_valid", bus.out_valid, 1'b1);
    check("ovl_old_table", bus.out, 1'b1);
    check("ovl_configured", bus.configured, 1'b0);
    check("ovl_in_ready", bus.in_ready, 1'b0);
    load(all01, DEPTH, 1'b0);
    sweep("sweep_all01");

    // Restart after 4 beats; the colliding beat is discarded
    pulse_start();
    load(all10, 4, 1'b0);
    bus.cfg_start = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_code = 2'b11;
    tick();
    bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0;
    check("restart_no_done", bus.cfg_done, 1'b0);
    load(t1, DEPTH, 1'b0);
    sweep("sweep_restart");

    // Reset in the middle of a load
    pulse_start();
    load(all01, 4, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    foreach (model[i]) model[i] = 2'b00;
    check("midrst_configured", bus.configured, 1'b0);
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_out", bus.out, 1'b0);
    check("midrst_cfg_done", bus.cfg_done, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    pulse_start();
    load(all00, DEPTH, 1'b0);
    sweep("sweep_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
